// File: rtl/mc_ctrl_pkg.sv
// mc_ctrl_pkg
// Shared encodings for the multicycle RV32I control unit: FSM state codes,
// opcode constants, ALUOp / ALUControl codes and datapath select encodings.
// Ports: none (package).
package mc_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXECR  = 4'd6,
        S_EXECI  = 4'd7,
        S_ALUWB  = 4'd8,
        S_BEQ    = 4'd9,
        S_JAL    = 4'd10,
        S_TRAP   = 4'd11
    } state_t;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10
    } aluop_t;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_A     = 2'b10;

    localparam logic [1:0] SRCB_WD    = 2'b00;
    localparam logic [1:0] SRCB_IMM   = 2'b01;
    localparam logic [1:0] SRCB_FOUR  = 2'b10;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

    // Immediate format depends only on the opcode, independent of FSM state.
    function automatic logic [1:0] imm_src_of(input logic [6:0] op);
        case (op)
            OP_SW:   return IMM_S;
            OP_BEQ:  return IMM_B;
            OP_JAL:  return IMM_J;
            default: return IMM_I;
        endcase
    endfunction

endpackage

// File: rtl/mc_alu_dec.sv
// mc_alu_dec
// Combinational ALU decoder: maps ALUOp plus instruction fields to ALUControl.
// Ports:
//   aluop      in  2  add / sub / funct
//   funct3     in  3  Instr[14:12]
//   op5        in  1  Instr[5], distinguishes R-type from I-type
//   funct7b5   in  1  Instr[30]
//   alucontrol out 3  ALU operation code
module mc_alu_dec
    import mc_ctrl_pkg::*;
(
    input  logic [1:0] aluop,
    input  logic [2:0] funct3,
    input  logic       op5,
    input  logic       funct7b5,
    output logic [2:0] alucontrol
);

    always_comb begin
        alucontrol = ALU_ADD;
        case (aluop)
            ALUOP_SUB: alucontrol = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct3)
                    // Only R-type sub sets both bits; addi with Instr[30]=1 stays add.
                    3'b000:  alucontrol = (op5 & funct7b5) ? ALU_SUB : ALU_ADD;
                    3'b010:  alucontrol = ALU_SLT;
                    3'b110:  alucontrol = ALU_OR;
                    3'b111:  alucontrol = ALU_AND;
                    // Unsupported funct3 degrades to add rather than trapping.
                    default: alucontrol = ALU_ADD;
                endcase
            end
            default: alucontrol = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/mc_controller.sv
// mc_controller
// Moore FSM control unit for the multicycle RV32I datapath
// (lw, sw, R-type, I-type ALU, beq, jal; any other opcode traps).
// Ports:
//   clk         in   1  rising-edge clock
//   reset       in   1  asynchronous active-high reset
//   op          in   7  Instr[6:0]
//   funct3      in   3  Instr[14:12]
//   funct7b5    in   1  Instr[30]
//   zero        in   1  ALU zero flag
//   PCWrite     out  1  PC enable
//   IRWrite     out  1  instruction / OldPC enable
//   RegWrite    out  1  register-file write enable
//   MemWrite    out  1  data-memory write strobe
//   AddrSrc     out  1  memory address: 0=PC, 1=Result
//   ALUSrcA     out  2  00=PC, 01=OldPC, 10=A
//   ALUSrcB     out  2  00=WriteData, 01=ImmExt, 10=4
//   ResultSrc   out  2  00=ALUOut, 01=Data, 10=ALUResult
//   ImmSrc      out  2  00=I, 01=S, 10=B, 11=J
//   ALUControl  out  3  ALU operation
//   illegal     out  1  sticky unsupported-opcode flag
//
// state    | meaning
// FETCH    | read instr at PC, PC <= PC+4
// DECODE   | ALUOut <= OldPC+imm (branch/jump target), dispatch on op
// MEMADR   | address = A+imm
// MEMRD    | read data memory at ALUOut
// MEMWB    | rd <= loaded data
// MEMWR    | write data memory at ALUOut
// EXECR    | A op B
// EXECI    | A op imm
// ALUWB    | rd <= ALUOut
// BEQ      | compare A-B, branch to ALUOut if zero
// JAL      | PC <= target, ALUOut <= OldPC+4
// TRAP     | unsupported opcode, hold until reset
module mc_controller
    import mc_ctrl_pkg::*;
#(
    parameter state_t RESET_STATE = S_FETCH
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       zero,
    output logic       PCWrite,
    output logic       IRWrite,
    output logic       RegWrite,
    output logic       MemWrite,
    output logic       AddrSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ResultSrc,
    output logic [1:0] ImmSrc,
    output logic [2:0] ALUControl,
    output logic       illegal
);

    state_t     state, state_next;
    aluop_t     aluop;
    logic       pc_update, branch;
    logic       ir_write_s, reg_write_s, mem_write_s, addr_src_s, illegal_s;
    logic [1:0] src_a_s, src_b_s, result_src_s;
    logic [2:0] alu_ctl;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= RESET_STATE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = S_FETCH;
        case (state)
            S_FETCH:  state_next = S_DECODE;
            S_DECODE: begin
                case (op)
                    OP_LW, OP_SW: state_next = S_MEMADR;
                    OP_R:         state_next = S_EXECR;
                    OP_I:         state_next = S_EXECI;
                    OP_BEQ:       state_next = S_BEQ;
                    OP_JAL:       state_next = S_JAL;
                    default:      state_next = S_TRAP;
                endcase
            end
            S_MEMADR: state_next = (op == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:  state_next = S_MEMWB;
            S_MEMWB:  state_next = S_FETCH;
            S_MEMWR:  state_next = S_FETCH;
            S_EXECR:  state_next = S_ALUWB;
            S_EXECI:  state_next = S_ALUWB;
            S_ALUWB:  state_next = S_FETCH;
            S_BEQ:    state_next = S_FETCH;
            S_JAL:    state_next = S_ALUWB;
            S_TRAP:   state_next = S_TRAP;
            default:  state_next = S_FETCH;
        endcase
    end

    always_comb begin
        pc_update    = 1'b0;
        branch       = 1'b0;
        ir_write_s   = 1'b0;
        reg_write_s  = 1'b0;
        mem_write_s  = 1'b0;
        addr_src_s   = 1'b0;
        illegal_s    = 1'b0;
        src_a_s      = SRCA_PC;
        src_b_s      = SRCB_WD;
        result_src_s = RES_ALUOUT;
        aluop        = ALUOP_ADD;
        case (state)
            S_FETCH: begin
                ir_write_s   = 1'b1;
                pc_update    = 1'b1;
                src_b_s      = SRCB_FOUR;
                result_src_s = RES_ALURESULT;
            end
            S_DECODE: begin
                src_a_s = SRCA_OLDPC;
                src_b_s = SRCB_IMM;
            end
            S_MEMADR: begin
                src_a_s = SRCA_A;
                src_b_s = SRCB_IMM;
            end
            S_MEMRD:  addr_src_s = 1'b1;
            S_MEMWB: begin
                result_src_s = RES_DATA;
                reg_write_s  = 1'b1;
            end
            S_MEMWR: begin
                addr_src_s  = 1'b1;
                mem_write_s = 1'b1;
            end
            S_EXECR: begin
                src_a_s = SRCA_A;
                aluop   = ALUOP_FUNCT;
            end
            S_EXECI: begin
                src_a_s = SRCA_A;
                src_b_s = SRCB_IMM;
                aluop   = ALUOP_FUNCT;
            end
            S_ALUWB:  reg_write_s = 1'b1;
            S_BEQ: begin
                src_a_s = SRCA_A;
                aluop   = ALUOP_SUB;
                branch  = 1'b1;
            end
            S_JAL: begin
                src_a_s   = SRCA_OLDPC;
                src_b_s   = SRCB_FOUR;
                pc_update = 1'b1;
            end
            S_TRAP:   illegal_s = 1'b1;
            default: ;
        endcase
    end

    mc_alu_dec u_alu_dec (
        .aluop      (aluop),
        .funct3     (funct3),
        .op5        (op[5]),
        .funct7b5   (funct7b5),
        .alucontrol (alu_ctl)
    );

    // State is already FETCH while reset is held, so gate outputs explicitly
    // to keep every strobe quiet until reset is released.
    assign PCWrite    = ~reset & (pc_update | (branch & zero));
    assign IRWrite    = ~reset & ir_write_s;
    assign RegWrite   = ~reset & reg_write_s;
    assign MemWrite   = ~reset & mem_write_s;
    assign AddrSrc    = ~reset & addr_src_s;
    assign illegal    = ~reset & illegal_s;
    assign ALUSrcA    = reset ? SRCA_PC    : src_a_s;
    assign ALUSrcB    = reset ? SRCB_WD    : src_b_s;
    assign ResultSrc  = reset ? RES_ALUOUT : result_src_s;
    assign ALUControl = reset ? ALU_ADD    : alu_ctl;
    assign ImmSrc     = imm_src_of(op);

endmodule

// File: tb/tb_mc_controller.sv
module tb_mc_controller;

    logic       clk, reset;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5, zero;
    logic       PCWrite, IRWrite, RegWrite, MemWrite, AddrSrc, illegal;
    logic [1:0] ALUSrcA, ALUSrcB, ResultSrc, ImmSrc;
    logic [2:0] ALUControl;

    int n_checks = 0;
    int n_fail   = 0;
    int zero_mode = 2;   // 0 force 0, 1 force 1, 2 random

    mc_controller dut (
        .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5),
        .zero(zero), .PCWrite(PCWrite), .IRWrite(IRWrite), .RegWrite(RegWrite),
        .MemWrite(MemWrite), .AddrSrc(AddrSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
        .ResultSrc(ResultSrc), .ImmSrc(ImmSrc), .ALUControl(ALUControl), .illegal(illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Observed vector layout:
    // {PCWrite, IRWrite, RegWrite, MemWrite, AddrSrc, ALUSrcA, ALUSrcB,
    //  ResultSrc, ImmSrc, ALUControl, illegal}
    function automatic logic [16:0] observed();
        return {PCWrite, IRWrite, RegWrite, MemWrite, AddrSrc, ALUSrcA, ALUSrcB,
                ResultSrc, ImmSrc, ALUControl, illegal};
    endfunction

    function automatic logic [1:0] imm_ref(input logic [6:0] o);
        if (o == 7'b0100011) return 2'b01;
        if (o == 7'b1100011) return 2'b10;
        if (o == 7'b1101111) return 2'b11;
        return 2'b00;
    endfunction

    function automatic logic [2:0] alu_ref(input logic [2:0] f3, input logic op5, input logic f7);
        case (f3)
            3'b000:  return (op5 && f7) ? 3'b001 : 3'b000;
            3'b010:  return 3'b101;
            3'b110:  return 3'b011;
            3'b111:  return 3'b010;
            default: return 3'b000;
        endcase
    endfunction

    function automatic bit is_legal(input logic [6:0] o);
        return o == 7'b0000011 || o == 7'b0100011 || o == 7'b0110011 ||
               o == 7'b0010011 || o == 7'b1100011 || o == 7'b1101111;
    endfunction

    function automatic int latency(input logic [6:0] o);
        case (o)
            7'b0000011: return 5;
            7'b0100011: return 4;
            7'b0110011: return 4;
            7'b0010011: return 4;
            7'b1100011: return 3;
            7'b1101111: return 4;
            default:    return 8;   // trap: observe decode plus several held cycles
        endcase
    endfunction

    // Expected control word for cycle 'cyc' (1-based) of an instruction.
    function automatic logic [16:0] model(input logic [6:0] o, input logic [2:0] f3,
                                          input logic f7, input logic z, input int cyc);
        logic pcw, irw, rw, mw, as, il;
        logic [1:0] sa, sb, rs;
        logic [2:0] ac;
        pcw = 0; irw = 0; rw = 0; mw = 0; as = 0; il = 0;
        sa = 2'b00; sb = 2'b00; rs = 2'b00; ac = 3'b000;
        if (cyc == 1) begin
            pcw = 1; irw = 1; sb = 2'b10; rs = 2'b10;
        end else if (cyc == 2) begin
            sa = 2'b01; sb = 2'b01;
        end else begin
            case (o)
                7'b0000011: begin
                    if (cyc == 3) begin sa = 2'b10; sb = 2'b01; end
                    if (cyc == 4) as = 1;
                    if (cyc == 5) begin rs = 2'b01; rw = 1; end
                end
                7'b0100011: begin
                    if (cyc == 3) begin sa = 2'b10; sb = 2'b01; end
                    if (cyc == 4) begin as = 1; mw = 1; end
                end
                7'b0110011: begin
                    if (cyc == 3) begin sa = 2'b10; ac = alu_ref(f3, o[5], f7); end
                    if (cyc == 4) rw = 1;
                end
                7'b0010011: begin
                    if (cyc == 3) begin sa = 2'b10; sb = 2'b01; ac = alu_ref(f3, o[5], f7); end
                    if (cyc == 4) rw = 1;
                end
                7'b1100011: begin
                    sa = 2'b10; ac = 3'b001; pcw = z;
                end
                7'b1101111: begin
                    if (cyc == 3) begin sa = 2'b01; sb = 2'b10; pcw = 1; end
                    if (cyc == 4) rw = 1;
                end
                default: il = 1;
            endcase
        end
        return {pcw, irw, rw, mw, as, sa, sb, rs, imm_ref(o), ac, il};
    endfunction

    task automatic check(input string tag, input logic [16:0] obs, input logic [16:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Entered at a negedge with the DUT in FETCH; leaves at the negedge after
    // the last cycle (back in FETCH unless the op trapped).
    task automatic run_instr(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                             input string name);
        op = o; funct3 = f3; funct7b5 = f7;
        for (int c = 1; c <= latency(o); c++) begin
            zero = (zero_mode == 2) ? 1'($urandom) : 1'(zero_mode);
            #1;
            check($sformatf("%s op=%b f3=%b c%0d", name, o, f3, c), observed(),
                  model(o, f3, f7, zero, c));
            @(negedge clk);
        end
    endtask

    logic [6:0] legal_ops [6];
    logic [6:0] rop;

    initial begin
        legal_ops = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b1100011, 7'b1101111};
        reset = 1; op = 7'b0000011; funct3 = 0; funct7b5 = 0; zero = 1;
        #12;
        check("reset_quiet", observed(), {12'b0, 2'b00, 3'b000, 1'b0});
        @(negedge clk);
        reset = 0;

        run_instr(7'b0000011, 3'b010, 1'b0, "lw");
        run_instr(7'b0110011, 3'b000, 1'b1, "sub");
        zero_mode = 1;
        run_instr(7'b1100011, 3'b000, 1'b0, "beq_taken");
        zero_mode = 0;
        run_instr(7'b1100011, 3'b000, 1'b0, "beq_not_taken");
        zero_mode = 2;
        run_instr(7'b1101111, 3'b101, 1'b1, "jal");
        run_instr(7'b0100011, 3'b010, 1'b0, "sw");
        run_instr(7'b0010011, 3'b000, 1'b1, "addi_b30");

        for (int i = 0; i < 40; i++) begin
            run_instr(legal_ops[$urandom_range(0, 5)], 3'($urandom_range(0, 7)),
                      1'($urandom), "rand");
        end

        // Directed trap: illegal must hold until reset clears it.
        run_instr(7'b1111111, 3'b000, 1'b0, "trap");
        reset = 1;
        #1;
        check("trap_reset_clears", observed(), {12'b0, imm_ref(op), 3'b000, 1'b0});
        @(negedge clk);
        reset = 0;

        // Random illegal opcode.
        rop = 7'b1111111;
        for (int t = 0; t < 20; t++) begin
            rop = 7'($urandom);
            if (!is_legal(rop)) break;
        end
        if (is_legal(rop)) rop = 7'b0000000;
        run_instr(rop, 3'($urandom_range(0, 7)), 1'($urandom), "rand_trap");
        reset = 1;
        #1;
        check("rand_trap_reset", observed(), {12'b0, imm_ref(op), 3'b000, 1'b0});
        @(negedge clk);
        reset = 0;

        // Async reset during MEMRD of a lw.
        op = 7'b0000011; funct3 = 3'b010; funct7b5 = 0;
        for (int c = 1; c <= 4; c++) begin
            zero = 1'($urandom);
            #1;
            check($sformatf("lw_pre_reset c%0d", c), observed(), model(op, funct3, funct7b5, zero, c));
            if (c < 4) @(negedge clk);
        end
        #1;
        reset = 1;
        #1;
        check("async_reset_memrd", observed(), {12'b0, 2'b00, 3'b000, 1'b0});
        @(negedge clk);
        reset = 0;
        run_instr(7'b0000011, 3'b010, 1'b0, "lw_after_reset");
        run_instr(7'b0010011, 3'b110, 1'b0, "ori");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mc_controller.md
Name: mc_controller

Overview:
- Control unit for the multicycle RV32I datapath. It sequences one instruction at a time through fetch, decode, execute, memory and writeback.
- It drives every datapath select and enable, and the data-memory write strobe.
- Inputs are decoded fields of the latched instruction register plus the ALU zero flag.
- Supported instructions: lw, sw, R-type (add/sub/and/or/slt), I-type ALU (addi/andi/ori/slti), beq, jal. Any other opcode traps.

Parameters:
- RESET_STATE, 4'd0 (S_FETCH): state entered on reset; fixed encoding from the package.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high; forces S_FETCH and clears illegal.
- op  in  7  Instr[6:0].
- funct3  in  3  Instr[14:12].
- funct7b5  in  1  Instr[30].
- zero  in  1  ALU zero flag.
- PCWrite  out  1  PC register enable.
- IRWrite  out  1  instruction/OldPC register enable.
- RegWrite  out  1  register-file write enable.
- MemWrite  out  1  data-memory write strobe.
- AddrSrc  out  1  memory address select: 0=PC, 1=Result.
- ALUSrcA  out  2  00=PC, 01=OldPC, 10=A.
- ALUSrcB  out  2  00=WriteData, 01=ImmExt, 10=4.
- ResultSrc  out  2  00=ALUOut, 01=Data, 10=ALUResult (11 unused).
- ImmSrc  out  2  00=I, 01=S, 10=B, 11=J.
- ALUControl  out  3  000 add, 001 sub, 010 and, 011 or, 101 slt.
- illegal  out  1  sticky unsupported-opcode flag.

Behaviour:
- Moore FSM, 4-bit state register. All outputs not listed for a state are 0.
- During reset all strobes are 0 and illegal=0. State is S_FETCH, so the first cycle after reset deassertion is a fetch.
- ImmSrc is combinational from op in every state: lw/I-ALU→00, sw→01, beq→10, jal→11, other→00.
- PCWrite = PCUpdate | (Branch & zero).

State outputs and transitions:
- S_FETCH: AddrSrc=0, IRWrite=1, ALUSrcA=00, ALUSrcB=10, ALUOp=add, ResultSrc=10, PCUpdate=1. Next S_DECODE.
- S_DECODE: ALUSrcA=01, ALUSrcB=01, ALUOp=add (branch/jump target into ALUOut). Next state by op:
  - 0000011 or 0100011 → S_MEMADR
  - 0110011 → S_EXECR
  - 0010011 → S_EXECI
  - 1100011 → S_BEQ
  - 1101111 → S_JAL
  - else → S_TRAP
- S_MEMADR: ALUSrcA=10, ALUSrcB=01, add. Next S_MEMRD if op=lw, else S_MEMWR.
- S_MEMRD: ResultSrc=00, AddrSrc=1. Next S_MEMWB.
- S_MEMWB: ResultSrc=01, RegWrite=1. Next S_FETCH.
- S_MEMWR: ResultSrc=00, AddrSrc=1, MemWrite=1. Next S_FETCH.
- S_EXECR: ALUSrcA=10, ALUSrcB=00, ALUOp=funct. Next S_ALUWB.
- S_EXECI: ALUSrcA=10, ALUSrcB=01, ALUOp=funct. Next S_ALUWB.
- S_ALUWB: ResultSrc=00, RegWrite=1. Next S_FETCH.
- S_BEQ: ALUSrcA=10, ALUSrcB=00, ALUOp=sub, ResultSrc=00, Branch=1. Next S_FETCH.
- S_JAL: ALUSrcA=01, ALUSrcB=10, add, ResultSrc=00, PCUpdate=1 (PC←target, ALUOut←OldPC+4). Next S_ALUWB.
- S_TRAP: all strobes 0, illegal=1. Held until reset; no PC or register writes occur.

ALU decode:
- ALUOp add → 000; ALUOp sub → 001.
- ALUOp funct, by funct3:
  - 000 → sub if {op[5], funct7b5}=11, else add. addi with Instr[30]=1 stays add.
  - 010 → slt.
  - 110 → or.
  - 111 → and.
  - other → add, and the unsupported funct3 is not trapped.

Latency per instruction (cycles):
- lw 5; sw 4; R/I-ALU 4; beq 3; jal 4.

Boundary conditions:
- reset mid-instruction: state → S_FETCH immediately (asynchronous); all strobes 0 that cycle.
- zero is sampled only in S_BEQ.
- A decode-time opcode change is irrelevant because IRWrite=0 outside S_FETCH.
- Unreachable state encodings → S_FETCH next cycle with outputs 0.

Decomposition:
- Package mc_ctrl_pkg holds:
  - state encodings S_FETCH..S_TRAP
  - opcode constants OP_LW/OP_SW/OP_R/OP_I/OP_BEQ/OP_JAL
  - ALUOp codes and ALUControl codes
  - select encodings for ALUSrcA/B, ResultSrc, ImmSrc
- One sub-module, mc_alu_dec: combinational {ALUOp, funct3, op[5], funct7b5} → ALUControl.

Test Plan:
- Reset then op=0000011 (lw) → states FETCH, DECODE, MEMADR, MEMRD, MEMWB:
  - IRWrite=1 only in cycle 1
  - AddrSrc=1 in cycle 4
  - RegWrite=1 with ResultSrc=01 in cycle 5
  - then FETCH
- op=0110011, funct3=000, funct7b5=1 → EXECR with ALUControl=001, ALUSrcA=10, ALUSrcB=00. Then ALUWB with RegWrite=1.
- op=1100011 in S_BEQ:
  - zero=1 → PCWrite=1, ResultSrc=00
  - zero=0 → PCWrite=0
  - either way back to FETCH after 3 cycles
- op=1101111 → JAL cycle has PCWrite=1, ALUSrcA=01, ALUSrcB=10. Then ALUWB with RegWrite=1. ImmSrc=11 throughout.
- op=0100011 → MEMWR has MemWrite=1 for exactly one cycle and ImmSrc=01. op=1111111 → S_TRAP, illegal=1 and held; reset clears it.
- Assert reset asynchronously during S_MEMRD → all strobes 0 without a clock edge; after deassertion the first state is FETCH.
